// File: rtl/first_nios2_system_timestamp_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | first_nios2_system_timestamp_master_if: halfword Avalon-MM timer bus      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface first_nios2_system_timestamp_master_if;
  logic [3:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/first_nios2_system_timestamp_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | first_nios2_system_timestamp_master: programs and services the interval  |
// | timer; snapshot readback enabled by TIMESTAMP_MASTER_SNAP_READ_EN. Rev1.0|
// +--------------------------------------------------------------------------+
module first_nios2_system_timestamp_master #(
  parameter logic [3:0] TIMER_BASE = 4'h0,
  parameter int         COUNT_W    = 16
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  start,
  input  wire logic                  stop,
  input  wire logic [63:0]           cfg_period,
  input  wire logic                  cfg_continuous,
  output logic                       busy,
  output logic                       snap_valid,
  output logic [63:0]                snap_value,
  output logic [COUNT_W-1:0]         timeout_count,
  first_nios2_system_timestamp_master_if.master avm,
  input  wire logic                  timer_irq
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_P0     = 4'd1,
    S_WR_P1     = 4'd2,
    S_WR_P2     = 4'd3,
    S_WR_P3     = 4'd4,
    S_WR_CTRL   = 4'd5,
    S_WAIT_IRQ  = 4'd6,
    S_CLR_ST    = 4'd7,
    S_WR_SNAP   = 4'd8,
    S_RD_S      = 4'd9,
    S_CAP       = 4'd10,
    S_SNAP_DONE = 4'd11,
    S_STOP_CTRL = 4'd12
  } state_t;

  state_t             r_state;
  logic [63:0]        r_period;
  logic               r_cont;
  logic               r_busy;
  logic               r_stop_lat;
  logic               r_cs;
  logic               r_write_n;
  logic [3:0]         r_addr;
  logic [15:0]        r_wdata;
  logic [COUNT_W-1:0] r_count;
`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
  logic [1:0]         r_idx;
  logic [63:0]        r_shadow;
  logic               r_snap_valid;
  logic [63:0]        r_snap_value;
`endif

  logic        w_is_cmd;
  logic [3:0]  w_off;
  logic [15:0] w_data;
  logic        w_rd;
  logic [3:0]  w_addr;
  logic        w_acc;

  // Command decode: every bus-owning state names its register offset and data.
  always_comb begin
    w_is_cmd = 1'b1;
    w_off    = 4'h0;
    w_data   = 16'h0000;
    w_rd     = 1'b0;
    case (r_state)
      S_WR_P0:     begin w_off = 4'h2; w_data = r_period[15:0];  end
      S_WR_P1:     begin w_off = 4'h3; w_data = r_period[31:16]; end
      S_WR_P2:     begin w_off = 4'h4; w_data = r_period[47:32]; end
      S_WR_P3:     begin w_off = 4'h5; w_data = r_period[63:48]; end
      S_WR_CTRL:   begin w_off = 4'h1; w_data = {12'h000, 1'b0, 1'b1, r_cont, 1'b1}; end
      S_CLR_ST:    w_off = 4'h0;
`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
      S_WR_SNAP:   w_off = 4'h6;
      S_RD_S:      begin w_off = 4'h6 + {2'b00, r_idx}; w_rd = 1'b1; end
`endif
      S_STOP_CTRL: begin w_off = 4'h1; w_data = 16'h0008; end
      default:     w_is_cmd = 1'b0;
    endcase
  end

  assign w_addr = TIMER_BASE + w_off;
  assign w_acc  = r_cs & ~avm.avm_waitrequest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_period   <= 64'h0;
      r_cont     <= 1'b0;
      r_busy     <= 1'b0;
      r_stop_lat <= 1'b0;
      r_cs       <= 1'b0;
      r_write_n  <= 1'b1;
      r_addr     <= 4'h0;
      r_wdata    <= 16'h0000;
      r_count    <= '0;
`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
      r_idx        <= 2'd0;
      r_shadow     <= 64'h0;
      r_snap_valid <= 1'b0;
      r_snap_value <= 64'h0;
`endif
    end else begin
`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
      r_snap_valid <= 1'b0;
`endif
      // Stop outside WAIT_IRQ is remembered; later clears in the case below win.
      if (r_busy && stop && (r_state != S_WAIT_IRQ))
        r_stop_lat <= 1'b1;

      // Each command state first drives the bus, then waits for acceptance.
      if (w_is_cmd && !r_cs) begin
        r_cs      <= 1'b1;
        r_addr    <= w_addr;
        r_wdata   <= w_data;
        r_write_n <= w_rd;
      end else if (w_acc) begin
        r_cs      <= 1'b0;
        r_write_n <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_period <= cfg_period;
            r_cont   <= cfg_continuous;
            r_busy   <= 1'b1;
            r_state  <= S_WR_P0;
          end
        end
        S_WR_P0:   if (w_acc) r_state <= S_WR_P1;
        S_WR_P1:   if (w_acc) r_state <= S_WR_P2;
        S_WR_P2:   if (w_acc) r_state <= S_WR_P3;
        S_WR_P3:   if (w_acc) r_state <= S_WR_CTRL;
        S_WR_CTRL: if (w_acc) r_state <= S_WAIT_IRQ;
        S_WAIT_IRQ: begin
          if (stop || r_stop_lat)
            r_state <= S_STOP_CTRL;
          else if (timer_irq)
            r_state <= S_CLR_ST;
        end
        S_CLR_ST: begin
          if (w_acc) begin
            r_count <= r_count + COUNT_W'(1);
`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
            r_state <= S_WR_SNAP;
`else
            if (r_cont) begin
              r_state <= S_WAIT_IRQ;
            end else begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_stop_lat <= 1'b0;
            end
`endif
          end
        end
`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
        S_WR_SNAP: begin
          if (w_acc) begin
            r_idx   <= 2'd0;
            r_state <= S_RD_S;
          end
        end
        S_RD_S: if (w_acc) r_state <= S_CAP;
        S_CAP: begin
          // Read data arrives one cycle after the read is accepted.
          r_shadow[{r_idx, 4'b0000} +: 16] <= avm.avm_readdata;
          if (r_idx == 2'd3) begin
            r_state <= S_SNAP_DONE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_RD_S;
          end
        end
        S_SNAP_DONE: begin
          r_snap_value <= r_shadow;
          r_snap_valid <= 1'b1;
          if (r_cont) begin
            r_state <= S_WAIT_IRQ;
          end else begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_stop_lat <= 1'b0;
          end
        end
`endif
        S_STOP_CTRL: begin
          if (w_acc) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_stop_lat <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy              = r_busy;
  assign timeout_count     = r_count;
  assign avm.avm_address    = r_addr;
  assign avm.avm_chipselect = r_cs;
  assign avm.avm_write_n    = r_write_n;
  assign avm.avm_writedata  = r_wdata;

`ifdef TIMESTAMP_MASTER_SNAP_READ_EN
  assign snap_valid = r_snap_valid;
  assign snap_value = r_snap_value;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^avm.avm_readdata;
  assign snap_valid  = 1'b0;
  assign snap_value  = 64'h0;
`endif

endmodule
`default_nettype wire
